// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mux_pkg
//  Description : Shared mode encodings, state type and bus-slicing helper for
//                the round-robin multiplexer.
//  Revision    : 1.0  initial release
// ============================================================================
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Bit offset of channel idx inside a flattened bus of width-bit channels.
    function automatic int chan_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage : mux_pkg
`default_nettype wire

// File: rtl/rr_mux_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_mux_if
//  Description : Producer/consumer handshake bundle for rr_mux.
//  Revision    : 1.0  initial release
// ============================================================================
interface rr_mux_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = $clog2(CHANNELS);

    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          o;
    logic                      o_valid;
    logic                      o_ready;
    logic [SEL_W-1:0]          o_chan;

    // Multiplexer side
    modport slave (
        input  mode, sel, in_data, in_valid, o_ready,
        output in_ready, o, o_valid, o_chan
    );

    // Producers/consumer side
    modport master (
        output mode, sel, in_data, in_valid, o_ready,
        input  in_ready, o, o_valid, o_chan
    );

endinterface : rr_mux_if
`default_nettype wire

// File: rtl/rr_grant.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant
//  Description : Combinational rotating-priority search starting after ptr.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_grant #(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  wire logic [CHANNELS-1:0] req,
    input  wire logic [SEL_W-1:0]    ptr,
    output logic      [SEL_W-1:0]    grant_idx,
    output logic                     grant_vld
);

    int w_idx;

    // Walk from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        w_idx     = 0;
        for (int k = CHANNELS; k >= 1; k--) begin
            w_idx = (int'(ptr) + k) % CHANNELS;
            if (req[w_idx]) begin
                grant_vld = 1'b1;
                grant_idx = SEL_W'(w_idx);
            end
        end
    end

endmodule : rr_grant
`default_nettype wire

// File: rtl/rr_mux.sv
`default_nettype none
// ============================================================================
//  Module      : rr_mux
//  Description : Registered N-channel mux, direct-select or round-robin, with
//                valid/ready handshake on every channel and the output.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_mux
    import mux_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  wire logic clk,
    input  wire logic reset,
    rr_mux_if.slave   bus
);

    localparam int               SEL_W     = $clog2(CHANNELS);
    localparam logic [SEL_W-1:0] c_PTR_RST = SEL_W'(CHANNELS - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [WIDTH-1:0]    r_data;
    logic [SEL_W-1:0]    r_chan;
    logic [SEL_W-1:0]    r_ptr;

    logic                w_load_en;
    logic                w_sel_in_range;
    logic                w_sel_vld;
    logic [SEL_W-1:0]    w_rr_idx;
    logic                w_rr_vld;
    logic [SEL_W-1:0]    w_grant_idx;
    logic                w_grant_vld;
    logic                w_xfer;
    logic [CHANNELS-1:0] w_ready;

    assign w_load_en = (r_state == ST_EMPTY) | bus.o_ready;

    // Only a non-power-of-two channel count can see an out-of-range select.
    generate
        if (CHANNELS == (1 << SEL_W)) begin : g_sel_full
            assign w_sel_in_range = 1'b1;
        end else begin : g_sel_partial
            assign w_sel_in_range = ({1'b0, bus.sel} < (SEL_W+1)'(CHANNELS));
        end
    endgenerate

    assign w_sel_vld = w_sel_in_range && bus.in_valid[bus.sel];

    rr_grant #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_rr_grant (
        .req       (bus.in_valid),
        .ptr       (r_ptr),
        .grant_idx (w_rr_idx),
        .grant_vld (w_rr_vld)
    );

    always_comb begin
        w_grant_idx = bus.sel;
        w_grant_vld = w_sel_vld;
        if (bus.mode == MODE_RR) begin
            w_grant_idx = w_rr_idx;
            w_grant_vld = w_rr_vld;
        end
    end

    // A grant always names a valid channel, so ready alone implies transfer.
    assign w_xfer = !reset && w_load_en && w_grant_vld;

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_ready[i] = w_xfer && (w_grant_idx == SEL_W'(i));
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_xfer) w_state_nxt = ST_FULL;
            ST_FULL: begin
                if (w_xfer)            w_state_nxt = ST_FULL;
                else if (bus.o_ready)  w_state_nxt = ST_EMPTY;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_chan <= '0;
            r_ptr  <= c_PTR_RST;
        end else if (w_xfer) begin
            r_data <= bus.in_data[chan_lsb(int'(w_grant_idx), WIDTH) +: WIDTH];
            r_chan <= w_grant_idx;
            r_ptr  <= w_grant_idx;
        end
    end

    assign bus.in_ready = w_ready;
    assign bus.o        = r_data;
    assign bus.o_valid  = (r_state == ST_FULL);
    assign bus.o_chan   = r_chan;

endmodule : rr_mux
`default_nettype wire

// File: doc/rr_mux.md
# rr_mux

Parametrised, registered N-channel multiplexer with per-channel valid/ready handshake. It is the successor to the 16-bit two-input combinational mux. It adds configurable width and channel count, a registered output, and two selection modes: direct select, or round-robin arbitration among valid channels. It sits between multiple producers (e.g. register-file read ports, memory-mapped sources) and a single consumer on the Hack datapath.

## Interface
- `WIDTH`, 16, data width per channel in bits (≥1)
- `CHANNELS`, 4, number of input channels (≥2)
- `SEL_W`, `$clog2(CHANNELS)`, select/channel-index width (derived, not overridden)

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `mode`  in  1  0 = direct select, 1 = round-robin
- `sel`  in  SEL_W  channel index used in direct mode
- `in_data`  in  CHANNELS*WIDTH  flattened inputs; channel i at `[i*WIDTH +: WIDTH]`
- `in_valid`  in  CHANNELS  per-channel valid
- `in_ready`  out  CHANNELS  per-channel ready (one-hot or zero)
- `o`  out  WIDTH  registered output data
- `o_valid`  out  1  output register holds data
- `o_ready`  in  1  consumer accepts `o` this cycle
- `o_chan`  out  SEL_W  index of channel that produced `o`

## Operation
- State: single output register, FSM `EMPTY` (`o_valid`=0) / `FULL` (`o_valid`=1).
- `load_en = !o_valid | o_ready`.
- Grant, direct mode: channel `sel` if `in_valid[sel]` and `sel < CHANNELS`; otherwise no grant.
- Grant, round-robin mode: first channel with `in_valid` set, searching `ptr+1, ptr+2, …` modulo CHANNELS; `ptr` = last granted index.
- `in_ready[i] = load_en & (grant == i)`; at most one bit set; all zero with no grant.
- Transfer on `in_valid[g] & in_ready[g]`: `o <= in_data[g]`, `o_chan <= g`, `o_valid <= 1`, `ptr <= g`.
- `ptr` updates on every transfer in either mode, so round-robin resumes after the last served channel.
- Drain without new transfer (`o_valid & o_ready`, no grant): `o_valid <= 0`; `o` and `o_chan` hold their last values.
- Simultaneous drain and transfer: the register is overwritten, `o_valid` stays 1 (full throughput).
- `FULL` and `!o_ready`: `o`, `o_chan`, `o_valid` stable; `in_ready` all zero.
- `mode`/`sel` are sampled combinationally each cycle. A change affects the next grant only, never the held output.
- `sel` ≥ CHANNELS (non-power-of-2 CHANNELS): no grant, no transfer.

## Timing
- Reset values: `o`=0, `o_valid`=0, `o_chan`=0, `ptr`=CHANNELS-1 (first round-robin grant searches from channel 0).
- `in_ready` is combinational from `o_valid`, `o_ready`, `mode`, `sel`, `in_valid`, `ptr`. It is all zero while `reset` is high.
- Latency: input accepted at edge k appears on `o` with `o_valid`=1 after edge k.
- Throughput: one word per cycle while `o_ready`=1 and a grant exists.
- Reset mid-operation: the held word is discarded, `o_valid`=0 after the edge, and `ptr` is restored. No transfer on the reset edge.
- Round-robin fairness: with all CHANNELS valid and `o_ready`=1, each channel is served exactly once per CHANNELS consecutive transfers.

## Structure
- Package `mux_pkg`: `MODE_SEL`=1'b0, `MODE_RR`=1'b1, and a helper function for flattened-bus channel slicing.
- Sub-module `rr_grant` (parameters CHANNELS, SEL_W): inputs `req`, `ptr`; outputs `grant_idx`, `grant_vld`. Purely combinational rotating-priority search.
- Top level holds the mode mux, handshake logic, output register and `ptr` register.

## Test plan
- Reset: assert `reset` 2 cycles with all `in_valid`=1 → `o`=0, `o_valid`=0, `o_chan`=0, `in_ready`=0; first round-robin transfer after release is channel 0.
- Direct mode: `mode`=0, `sel`=2, `in_data` ch2=16'hBEEF, all valid, `o_ready`=1 → next cycle `o`=16'hBEEF, `o_chan`=2; `in_ready`=4'b0100 every cycle.
- Round-robin: `mode`=1, all 4 valid (ch i = 16'h0010+i), `o_ready`=1 → `o_chan` sequence 0,1,2,3,0; `o` = 16'h0010…16'h0013,16'h0010.
- Sparse round-robin: valid=4'b1010 → `o_chan` alternates 1,3,1; channels 0 and 2 never get `in_ready`.
- Backpressure: `o_ready`=0 for 5 cycles while FULL with 16'h1234 → `o`, `o_chan` stable, `in_ready`=0; `o_ready`=1 → new word next cycle, no gap.
- Mode switch and drain: 2 round-robin transfers (ch0, ch1), switch to `mode`=0, `sel`=3 for 1 transfer, back to `mode`=1 → next grant is ch0 (after ptr=3). With all valid low and `o_ready`=1, `o_valid` drops after one cycle.
